// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-port byte-enabled RAM. Port 0 has fixed
// priority; port 1 gets a forced grant after MAX_WAIT consecutive denials.
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req0,
    input  logic [ADDR_WIDTH-1:0]   addr0,
    input  logic [DATA_WIDTH-1:0]   din0,
    input  logic [DATA_WIDTH/8-1:0] we0,
    output logic                    gnt0,
    output logic                    rd_valid0,
    input  logic                    req1,
    input  logic [ADDR_WIDTH-1:0]   addr1,
    input  logic [DATA_WIDTH-1:0]   din1,
    input  logic [DATA_WIDTH/8-1:0] we1,
    output logic                    gnt1,
    output logic                    rd_valid1,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    output logic [DATA_WIDTH/8-1:0] ram_we,
    input  logic [DATA_WIDTH-1:0]   ram_dout
);

    localparam int          LANES      = DATA_WIDTH / 8;
    localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0] wait_cnt_r;
    logic       force_s;
    logic       rd0_s;
    logic       rd1_s;

    assign force_s = (wait_cnt_r == MAX_WAIT_C);
    assign rdata   = ram_dout;

    // Grant selection and RAM port mux; an idle cycle becomes a harmless port-0 read.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        ram_addr = addr0;
        ram_din  = din0;
        ram_we   = '0;
        if (req1 && (force_s || !req0)) begin
            gnt1     = 1'b1;
            ram_addr = addr1;
            ram_din  = din1;
            ram_we   = we1;
        end else if (req0) begin
            gnt0     = 1'b1;
            ram_addr = addr0;
            ram_din  = din0;
            ram_we   = we0;
        end else begin
            gnt0     = 1'b0;
            gnt1     = 1'b0;
        end
    end

    assign rd0_s = gnt0 && (we0 == {LANES{1'b0}});
    assign rd1_s = gnt1 && (we1 == {LANES{1'b0}});

    // Port-1 starvation counter, saturating at MAX_WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= 8'd0;
        end else if (!req1 || gnt1) begin
            wait_cnt_r <= 8'd0;
        end else if (wait_cnt_r < MAX_WAIT_C) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Read-return strobes, one cycle behind the granting cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid0 <= 1'b0;
            rd_valid1 <= 1'b0;
        end else begin
            rd_valid0 <= rd0_s;
            rd_valid1 <= rd1_s;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1;
    logic [11:0] addr0, addr1;
    logic [15:0] din0, din1;
    logic [1:0]  we0, we1;
    logic        gnt0, gnt1, rd_valid0, rd_valid1;
    logic [15:0] rdata, ram_din, ram_dout;
    logic [11:0] ram_addr;
    logic [1:0]  ram_we;
    logic [15:0] mem [0:4095];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .MAX_WAIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .addr0(addr0), .din0(din0), .we0(we0), .gnt0(gnt0), .rd_valid0(rd_valid0),
        .req1(req1), .addr1(addr1), .din1(din1), .we1(we1), .gnt1(gnt1), .rd_valid1(rd_valid1),
        .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    // Single-port RAM: byte-lane writes, registered read returning old data.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_we[i]) mem[ram_addr][i*8 +: 8] <= ram_din[i*8 +: 8];
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 1'b1; addr0 = 12'h005; din0 = 16'h0000; we0 = 2'b00;
        req1 = 1'b0; addr1 = 12'h000; din1 = 16'h0000; we1 = 2'b00;

        // Reset held with a pending port-0 read
        repeat (3) begin
            @(negedge clk);
            check("rst_rv0", 32'(rd_valid0), 32'd0);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("rel_gnt0", 32'(gnt0), 32'd1);
        check("rel_gnt1", 32'(gnt1), 32'd0);
        check("rel_rv0_early", 32'(rd_valid0), 32'd0);
        next_cycle(); req0 = 1'b0;
        @(negedge clk);
        check("rel_rv0", 32'(rd_valid0), 32'd1);
        check("idle_we", 32'(ram_we), 32'd0);

        // Port 0 full write then read
        next_cycle(); req0 = 1'b1; addr0 = 12'h010; din0 = 16'hA5C3; we0 = 2'b11;
        @(negedge clk);
        check("w0_gnt0", 32'(gnt0), 32'd1);
        check("w0_we", 32'(ram_we), 32'h3);
        check("w0_addr", 32'(ram_addr), 32'h010);
        next_cycle(); we0 = 2'b00;
        @(negedge clk);
        check("r0_gnt0", 32'(gnt0), 32'd1);
        check("r0_rv_after_wr", 32'(rd_valid0), 32'd0);
        next_cycle(); req0 = 1'b0;
        @(negedge clk);
        check("r0_rv0", 32'(rd_valid0), 32'd1);
        check("r0_rdata", 32'(rdata), 32'hA5C3);

        // Byte-lane write from port 1
        next_cycle(); req0 = 1'b1; addr0 = 12'h020; din0 = 16'h1234; we0 = 2'b11;
        next_cycle(); req0 = 1'b0; req1 = 1'b1; addr1 = 12'h020; din1 = 16'hFF00; we1 = 2'b10;
        @(negedge clk);
        check("bl_gnt1", 32'(gnt1), 32'd1);
        check("bl_we", 32'(ram_we), 32'h2);
        check("bl_din", 32'(ram_din), 32'hFF00);
        next_cycle(); we1 = 2'b00;
        @(negedge clk);
        check("bl_rd_gnt1", 32'(gnt1), 32'd1);
        next_cycle(); req1 = 1'b0;
        @(negedge clk);
        check("bl_rv1", 32'(rd_valid1), 32'd1);
        check("bl_rv0", 32'(rd_valid0), 32'd0);
        check("bl_rdata", 32'(rdata), 32'hFF34);

        // Contention: both ports reading continuously
        next_cycle(); req0 = 1'b1; addr0 = 12'h010; we0 = 2'b00; req1 = 1'b1; addr1 = 12'h020; we1 = 2'b00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("ct_gnt1", 32'(gnt1), 32'((c % 5) == 4));
            check("ct_gnt0", 32'(gnt0), 32'((c % 5) != 4));
            check("ct_wait", 32'(dut.wait_cnt_r), 32'(c % 5));
            check("ct_rv1", 32'(rd_valid1), 32'(c >= 1 && ((c - 1) % 5) == 4));
            check("ct_rv0", 32'(rd_valid0), 32'(c >= 1 && ((c - 1) % 5) != 4));
            if (c >= 1) check("ct_rdata", 32'(rdata), (((c - 1) % 5) == 4) ? 32'hFF34 : 32'hA5C3);
            next_cycle();
        end

        // Port 1 alone (already inside the next cycle)
        req0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("solo_gnt1", 32'(gnt1), 32'd1);
            check("solo_gnt0", 32'(gnt0), 32'd0);
            check("solo_wait", 32'(dut.wait_cnt_r), 32'd0);
            check("solo_rv1", 32'(rd_valid1), 32'd1);
            next_cycle();
        end

        // No requests
        req1 = 1'b0;
        @(negedge clk);
        check("idle_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("idle_we2", 32'(ram_we), 32'd0);
        next_cycle();
        @(negedge clk);
        check("idle_rv", 32'({rd_valid0, rd_valid1}), 32'd0);
        check("idle_addr", 32'(ram_addr), 32'h010);

        // Interleaved single-port reads
        for (int k = 0; k < 6; k++) begin
            next_cycle(); req0 = ((k % 2) == 0); req1 = ((k % 2) == 1);
            @(negedge clk);
            check("il_gnt0", 32'(gnt0), 32'((k % 2) == 0));
            check("il_gnt1", 32'(gnt1), 32'((k % 2) == 1));
            check("il_rv0", 32'(rd_valid0), 32'(k >= 1 && ((k - 1) % 2) == 0));
            check("il_rv1", 32'(rd_valid1), 32'(k >= 1 && ((k - 1) % 2) == 1));
            if (k >= 1) check("il_rdata", 32'(rdata), (((k - 1) % 2) == 0) ? 32'hA5C3 : 32'hFF34);
        end
        next_cycle(); req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("il_last_rv1", 32'(rd_valid1), 32'd1);
        check("il_last_rv0", 32'(rd_valid0), 32'd0);

        // Reset lands on a granted read: its strobe must never appear
        next_cycle(); req0 = 1'b1;
        @(negedge clk);
        check("inf_gnt0", 32'(gnt0), 32'd1);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        check("inf_rv0_rst", 32'(rd_valid0), 32'd0);
        req0 = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        check("inf_rv0_rel", 32'(rd_valid0), 32'd0);
        next_cycle();
        @(negedge clk);
        check("inf_rv0_after", 32'(rd_valid0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Two-requester arbiter sharing one 16-bit single-port RAM with byte write enables and 1-cycle registered read latency. Port 0 is the CPU side and has fixed priority. Port 1 is the DMA/debug side and is protected by a starvation counter. The block sits between the requesters and the RAM, muxes address, data and write-enables, and returns read data tagged with a per-port valid strobe.

Parameters:
ADDR_WIDTH, 12, RAM word-address width
DATA_WIDTH, 16, RAM data width; byte lanes = DATA_WIDTH/8
MAX_WAIT, 4, consecutive denied cycles for port 1 before forced grant; legal range 1..255

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
req0  input  1  port 0 access request; held with addr0/din0/we0 until gnt0
addr0  input  ADDR_WIDTH  port 0 word address
din0  input  DATA_WIDTH  port 0 write data
we0  input  DATA_WIDTH/8  port 0 byte write enables; all-zero = read
gnt0  output  1  port 0 granted this cycle (combinational)
rd_valid0  output  1  ram_dout is port 0 read data this cycle (registered)
req1, addr1, din1, we1, gnt1, rd_valid1  same as port 0, for port 1
rdata  output  DATA_WIDTH  read data to both ports, = ram_dout
ram_addr  output  ADDR_WIDTH  RAM address
ram_din  output  DATA_WIDTH  RAM write data
ram_we  output  DATA_WIDTH/8  RAM byte write enables
ram_dout  input  DATA_WIDTH  RAM read data, valid 1 cycle after address

Behaviour:
- Reset (async, reset_n=0): rd_valid0=rd_valid1=0, wait_cnt=0. A read in flight is discarded; no rd_valid fires after reset is released.
- gnt0/gnt1 and the ram_* muxing are combinational from req0/req1 and wait_cnt. At most one grant per cycle. A transfer occurs on every cycle where gntX=1.
- Grant rule, evaluated per cycle:
  - force = (wait_cnt == MAX_WAIT).
  - If req1 and (force or !req0), then gnt1=1.
  - Else if req0, then gnt0=1.
  - Else no grant.
- wait_cnt (8-bit) on each clock edge:
  - req1 && !gnt1: increment, saturating at MAX_WAIT.
  - gnt1: clear to 0.
  - !req1: clear to 0.
- RAM mux:
  - Granted port drives ram_addr, ram_din and ram_we.
  - No grant: ram_we=0, ram_addr=addr0, ram_din=din0. This is a harmless read.
- Read return: rd_validX is registered 1 if gntX && weX==0 in the previous cycle, else 0. rdata = ram_dout unregistered. Latency is grant cycle + 1.
- Writes return no strobe and complete on the grant edge.
- Back-to-back: a port may be granted on consecutive cycles. Full throughput is 1 access/cycle, with rd_valid pipelined one behind.
- Read-during-write to the same address follows RAM behaviour (old data); the arbiter adds no forwarding.
- A requester must not change addr/din/we while reqX=1 && gntX=0. A request may be dropped only after its grant; behaviour for a dropped ungranted request is defined only as "no access".
- Partial byte writes pass ram_we through unchanged; only the selected lanes are written.
- MAX_WAIT bounds port-1 latency to MAX_WAIT+1 cycles under continuous port-0 load.

Test Plan:
- Reset: hold reset_n=0 with req0=1 and a read issued the cycle before → rd_valid0=0 throughout; after release, gnt0=1 first cycle, rd_valid0=1 one cycle later.
- Port 0 write 0xA5C3 to addr 0x010 with we0=2'b11, then read 0x010 → gnt0 both cycles; rdata=0xA5C3 with rd_valid0=1 one cycle after the read grant.
- Byte lane: write 0x1234 to 0x020, then port 1 writes 0xFF00 with we1=2'b10, then reads → rdata=0xFF34, rd_valid1=1, rd_valid0=0.
- Contention, MAX_WAIT=4: req0 and req1 held high continuously → gnt0 for 4 cycles, gnt1 on cycle 5, wait_cnt back to 0; pattern repeats every 5 cycles.
- Idle/solo: only req1 asserted → gnt1 every cycle, wait_cnt stays 0; no requests → ram_we=0, no rd_valid.
- Interleaved reads alternating ports on consecutive cycles → each rd_valid fires exactly once, one cycle after its own grant, never both in the same cycle.
